// File: rtl/my_axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register slice.
package my_axil_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_SIMPLE = 2'd1,
    SLICE_SKID   = 2'd2
  } slice_mode_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int axil_strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/my_axil_if.sv
// AXI4-Lite bundle with master/slave views.
interface my_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import my_axil_pkg::*;

  localparam int STRB_W = axil_strb_w(DATA_W);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/my_axil_skid_buf.sv
// Generic valid/ready slice: bypass, one-entry register or two-entry skid buffer.
module my_axil_skid_buf
  import my_axil_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter slice_mode_e MODE  = SLICE_SKID
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE == SLICE_BYPASS) begin : g_bypass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign out_valid  = in_valid;
    assign out_data   = in_data;
    assign in_ready   = out_ready;

  end else if (MODE == SLICE_SIMPLE) begin : g_simple
    logic             full_p0;
    logic             rdy_p0;
    logic [WIDTH-1:0] data_p0;
    logic             in_hs;
    logic             out_hs;
    logic             full_nxt;

    assign in_hs  = in_valid & rdy_p0;
    assign out_hs = full_p0 & out_ready;

    always_comb begin
      full_nxt = full_p0;
      if (in_hs)       full_nxt = 1'b1;
      else if (out_hs) full_nxt = 1'b0;
    end

    // stage p0: single holding register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_p0 <= 1'b0;
        rdy_p0  <= 1'b0;
        data_p0 <= '0;
      end else begin
        full_p0 <= full_nxt;
        rdy_p0  <= ~full_nxt;
        if (in_hs) data_p0 <= in_data;
      end
    end

    assign out_valid = full_p0;
    assign out_data  = data_p0;
    assign in_ready  = rdy_p0;

  end else begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

    skid_state_e      state_p0;
    skid_state_e      state_nxt;
    logic             rdy_p0;
    logic [WIDTH-1:0] main_p0;
    logic [WIDTH-1:0] skid_p0;
    logic             in_hs;
    logic             out_hs;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign in_hs  = in_valid & rdy_p0;
    assign out_hs = (state_p0 != EMPTY) & out_ready;

    always_comb begin
      state_nxt      = state_p0;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_p0)
        EMPTY: if (in_hs) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (in_hs && out_hs) begin
            load_main = 1'b1;
          end else if (in_hs) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (out_hs) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (out_hs) begin
          state_nxt      = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end

    // stage p0: main register plus skid overflow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_p0 <= EMPTY;
        rdy_p0   <= 1'b0;
        main_p0  <= '0;
        skid_p0  <= '0;
      end else begin
        state_p0 <= state_nxt;
        rdy_p0   <= (state_nxt != TWO);
        if (load_main) main_p0 <= main_from_skid ? skid_p0 : in_data;
        if (load_skid) skid_p0 <= in_data;
      end
    end

    assign out_valid = (state_p0 != EMPTY);
    assign out_data  = main_p0;
    assign in_ready  = rdy_p0;
  end

endmodule

// File: rtl/my_axil_reg_slice.sv
// AXI4-Lite register slice, per-channel bypass/simple/skid.
// Optional handshake counters with MY_AXIL_SLICE_STATS_EN.
module my_axil_reg_slice
  import my_axil_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter slice_mode_e AW_MODE = SLICE_SKID,
  parameter slice_mode_e W_MODE  = SLICE_SKID,
  parameter slice_mode_e B_MODE  = SLICE_SIMPLE,
  parameter slice_mode_e AR_MODE = SLICE_SKID,
  parameter slice_mode_e R_MODE  = SLICE_SKID
) (
  input  logic      clk,
  input  logic      rst_n,
  my_axil_if.slave  s_axil,
  my_axil_if.master m_axil
`ifdef MY_AXIL_SLICE_STATS_EN
  ,
  output logic [31:0] wr_cnt,
  output logic [31:0] rd_cnt
`endif
);

  localparam int STRB_W = axil_strb_w(DATA_W);
  localparam int AX_W   = ADDR_W + 3;
  localparam int W_W    = DATA_W + STRB_W;
  localparam int R_W    = DATA_W + 2;

  logic [AX_W-1:0] aw_out;
  logic [AX_W-1:0] ar_out;
  logic [W_W-1:0]  w_out;
  logic [R_W-1:0]  r_out;

  my_axil_skid_buf #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_axil.awvalid),
    .in_ready  (s_axil.awready),
    .in_data   ({s_axil.awaddr, s_axil.awprot}),
    .out_valid (m_axil.awvalid),
    .out_ready (m_axil.awready),
    .out_data  (aw_out)
  );
  assign m_axil.awaddr = aw_out[AX_W-1:3];
  assign m_axil.awprot = aw_out[2:0];

  my_axil_skid_buf #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_axil.wvalid),
    .in_ready  (s_axil.wready),
    .in_data   ({s_axil.wdata, s_axil.wstrb}),
    .out_valid (m_axil.wvalid),
    .out_ready (m_axil.wready),
    .out_data  (w_out)
  );
  assign m_axil.wdata = w_out[W_W-1:STRB_W];
  assign m_axil.wstrb = w_out[STRB_W-1:0];

  // Response channels run slave-to-master
  my_axil_skid_buf #(.WIDTH(2), .MODE(B_MODE)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_axil.bvalid),
    .in_ready  (m_axil.bready),
    .in_data   (m_axil.bresp),
    .out_valid (s_axil.bvalid),
    .out_ready (s_axil.bready),
    .out_data  (s_axil.bresp)
  );

  my_axil_skid_buf #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_axil.arvalid),
    .in_ready  (s_axil.arready),
    .in_data   ({s_axil.araddr, s_axil.arprot}),
    .out_valid (m_axil.arvalid),
    .out_ready (m_axil.arready),
    .out_data  (ar_out)
  );
  assign m_axil.araddr = ar_out[AX_W-1:3];
  assign m_axil.arprot = ar_out[2:0];

  my_axil_skid_buf #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_axil.rvalid),
    .in_ready  (m_axil.rready),
    .in_data   ({m_axil.rdata, m_axil.rresp}),
    .out_valid (s_axil.rvalid),
    .out_ready (s_axil.rready),
    .out_data  (r_out)
  );
  assign s_axil.rdata = r_out[R_W-1:2];
  assign s_axil.rresp = r_out[1:0];

`ifdef MY_AXIL_SLICE_STATS_EN
  // stage p0: upstream completion counters, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (s_axil.bvalid && s_axil.bready) wr_cnt <= wr_cnt + 32'd1;
      if (s_axil.rvalid && s_axil.rready) rd_cnt <= rd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_my_axil_reg_slice.sv
// Scoreboard bench for my_axil_reg_slice (default modes plus an R-bypass instance).
module tb_my_axil_reg_slice;
  import my_axil_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  my_axil_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  my_axil_if #(.ADDR_W(32), .DATA_W(32)) m_if ();
  my_axil_if #(.ADDR_W(32), .DATA_W(32)) sb_if ();
  my_axil_if #(.ADDR_W(32), .DATA_W(32)) mb_if ();

`ifdef MY_AXIL_SLICE_STATS_EN
  logic [31:0] wr_cnt, rd_cnt, wr_cnt_b, rd_cnt_b;
`endif

  my_axil_reg_slice #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axil (s_if),
    .m_axil (m_if)
`ifdef MY_AXIL_SLICE_STATS_EN
    ,
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt)
`endif
  );

  my_axil_reg_slice #(.ADDR_W(32), .DATA_W(32), .R_MODE(SLICE_BYPASS)) dut_byp (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axil (sb_if),
    .m_axil (mb_if)
`ifdef MY_AXIL_SLICE_STATS_EN
    ,
    .wr_cnt (wr_cnt_b),
    .rd_cnt (rd_cnt_b)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: each channel is an in-order FIFO of accepted beats.
  logic [63:0] q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$], q_rb[$];
  int t_aw[$], t_w[$], t_b[$], t_ar[$], t_r[$], t_rb[$];
  int aw_out_log[$], aw_lat_log[$], ar_out_log[$];
  logic [31:0] exp_wr = '0, exp_rd = '0;
  logic pv_awv = 0, pv_awr = 0, pv_arv = 0, pv_arr = 0, pv_bv = 0, pv_br = 0, pv_rv = 0, pv_rr = 0;
  logic [34:0] pv_aw = '0, pv_ar = '0;
  logic [1:0]  pv_b = '0;
  logic [33:0] pv_r = '0;

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      if (s_if.awvalid && s_if.awready) begin q_aw.push_back({s_if.awaddr, s_if.awprot}); t_aw.push_back(cyc); end
      if (s_if.wvalid && s_if.wready)   begin q_w.push_back({s_if.wdata, s_if.wstrb});    t_w.push_back(cyc);  end
      if (s_if.arvalid && s_if.arready) begin q_ar.push_back({s_if.araddr, s_if.arprot}); t_ar.push_back(cyc); end
      if (m_if.bvalid && m_if.bready)   begin q_b.push_back(m_if.bresp);                  t_b.push_back(cyc);  end
      if (m_if.rvalid && m_if.rready)   begin q_r.push_back({m_if.rdata, m_if.rresp});    t_r.push_back(cyc);  end
      if (mb_if.rvalid && mb_if.rready) begin q_rb.push_back({mb_if.rdata, mb_if.rresp}); t_rb.push_back(cyc); end

      if (m_if.awvalid && m_if.awready) begin
        chk("aw_beat_expected", q_aw.size() != 0, 1);
        if (q_aw.size() != 0) begin
          chk("aw_payload", {m_if.awaddr, m_if.awprot}, q_aw[0]);
          chk("aw_latency_ge1", (cyc - t_aw[0]) >= 1, 1);
          aw_out_log.push_back(cyc);
          aw_lat_log.push_back(cyc - t_aw[0]);
          q_aw.delete(0); t_aw.delete(0);
        end
      end
      if (m_if.wvalid && m_if.wready) begin
        chk("w_beat_expected", q_w.size() != 0, 1);
        if (q_w.size() != 0) begin
          chk("w_payload", {m_if.wdata, m_if.wstrb}, q_w[0]);
          chk("w_latency_ge1", (cyc - t_w[0]) >= 1, 1);
          q_w.delete(0); t_w.delete(0);
        end
      end
      if (m_if.arvalid && m_if.arready) begin
        chk("ar_beat_expected", q_ar.size() != 0, 1);
        if (q_ar.size() != 0) begin
          chk("ar_payload", {m_if.araddr, m_if.arprot}, q_ar[0]);
          chk("ar_latency_ge1", (cyc - t_ar[0]) >= 1, 1);
          ar_out_log.push_back(cyc);
          q_ar.delete(0); t_ar.delete(0);
        end
      end
      if (s_if.bvalid && s_if.bready) begin
        exp_wr <= exp_wr + 32'd1;
        chk("b_beat_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          chk("b_payload", s_if.bresp, q_b[0]);
          chk("b_latency_ge1", (cyc - t_b[0]) >= 1, 1);
          q_b.delete(0); t_b.delete(0);
        end
      end
      if (s_if.rvalid && s_if.rready) begin
        exp_rd <= exp_rd + 32'd1;
        chk("r_beat_expected", q_r.size() != 0, 1);
        if (q_r.size() != 0) begin
          chk("r_payload", {s_if.rdata, s_if.rresp}, q_r[0]);
          chk("r_latency_ge1", (cyc - t_r[0]) >= 1, 1);
          q_r.delete(0); t_r.delete(0);
        end
      end
      if (sb_if.rvalid && sb_if.rready) begin
        chk("byp_r_beat_expected", q_rb.size() != 0, 1);
        if (q_rb.size() != 0) begin
          chk("byp_r_payload", {sb_if.rdata, sb_if.rresp}, q_rb[0]);
          chk("byp_r_latency0", cyc - t_rb[0], 0);
          q_rb.delete(0); t_rb.delete(0);
        end
      end

      // A stalled output must keep valid high and payload frozen
      if (pv_awv && !pv_awr) begin
        chk("aw_valid_hold", m_if.awvalid, 1);
        chk("aw_stable", {m_if.awaddr, m_if.awprot}, pv_aw);
      end
      if (pv_arv && !pv_arr) begin
        chk("ar_valid_hold", m_if.arvalid, 1);
        chk("ar_stable", {m_if.araddr, m_if.arprot}, pv_ar);
      end
      if (pv_bv && !pv_br) begin
        chk("b_valid_hold", s_if.bvalid, 1);
        chk("b_stable", s_if.bresp, pv_b);
      end
      if (pv_rv && !pv_rr) begin
        chk("r_valid_hold", s_if.rvalid, 1);
        chk("r_stable", {s_if.rdata, s_if.rresp}, pv_r);
      end
    end
    pv_awv <= m_if.awvalid; pv_awr <= m_if.awready; pv_aw <= {m_if.awaddr, m_if.awprot};
    pv_arv <= m_if.arvalid; pv_arr <= m_if.arready; pv_ar <= {m_if.araddr, m_if.arprot};
    pv_bv  <= s_if.bvalid;  pv_br  <= s_if.bready;  pv_b  <= s_if.bresp;
    pv_rv  <= s_if.rvalid;  pv_rr  <= s_if.rready;  pv_r  <= {s_if.rdata, s_if.rresp};
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic send_aw_w(input logic [31:0] addr);
    bit ad, wd;
    int k;
    ad = 0; wd = 0; k = 0;
    s_if.awvalid = 1; s_if.awaddr = addr; s_if.awprot = 3'($urandom);
    s_if.wvalid = 1; s_if.wdata = $urandom; s_if.wstrb = 4'($urandom);
    while (!(ad && wd) && k < 50) begin
      @(negedge clk);
      if (s_if.awvalid && s_if.awready) ad = 1;
      if (s_if.wvalid && s_if.wready) wd = 1;
      @(posedge clk); #1;
      if (ad) s_if.awvalid = 0;
      if (wd) s_if.wvalid = 0;
      k++;
    end
    if (!(ad && wd)) chk("aw_w_send_timeout", {ad, wd}, 2'b11);
  endtask

  task automatic send_ar(input logic [31:0] addr);
    int k;
    k = 0;
    s_if.arvalid = 1; s_if.araddr = addr; s_if.arprot = 3'($urandom);
    @(negedge clk);
    while (!s_if.arready && k < 50) begin k++; @(negedge clk); end
    if (!s_if.arready) chk("ar_send_timeout", s_if.arready, 1);
    @(posedge clk); #1;
    s_if.arvalid = 0;
  endtask

  task automatic send_b(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      m_if.bvalid = 1; m_if.bresp = 2'($urandom);
      @(negedge clk);
      while (!m_if.bready && k < 50) begin k++; @(negedge clk); end
      if (!m_if.bready) chk("b_send_timeout", m_if.bready, 1);
      @(posedge clk); #1;
    end
    m_if.bvalid = 0;
  endtask

  task automatic send_r(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      m_if.rvalid = 1; m_if.rdata = $urandom; m_if.rresp = 2'($urandom);
      @(negedge clk);
      while (!m_if.rready && k < 50) begin k++; @(negedge clk); end
      if (!m_if.rready) chk("r_send_timeout", m_if.rready, 1);
      @(posedge clk); #1;
    end
    m_if.rvalid = 0;
  endtask

  task automatic random_phase(input int ncyc);
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      aw_hs = s_if.awvalid && s_if.awready;
      w_hs  = s_if.wvalid && s_if.wready;
      ar_hs = s_if.arvalid && s_if.arready;
      b_hs  = m_if.bvalid && m_if.bready;
      r_hs  = m_if.rvalid && m_if.rready;
      @(posedge clk); #1;
      if (!s_if.awvalid || aw_hs) begin
        s_if.awvalid = 1'($urandom_range(0, 1)); s_if.awaddr = $urandom; s_if.awprot = 3'($urandom);
      end
      if (!s_if.wvalid || w_hs) begin
        s_if.wvalid = 1'($urandom_range(0, 1)); s_if.wdata = $urandom; s_if.wstrb = 4'($urandom);
      end
      if (!s_if.arvalid || ar_hs) begin
        s_if.arvalid = 1'($urandom_range(0, 1)); s_if.araddr = $urandom; s_if.arprot = 3'($urandom);
      end
      if (!m_if.bvalid || b_hs) begin
        m_if.bvalid = 1'($urandom_range(0, 1)); m_if.bresp = 2'($urandom);
      end
      if (!m_if.rvalid || r_hs) begin
        m_if.rvalid = 1'($urandom_range(0, 1)); m_if.rdata = $urandom; m_if.rresp = 2'($urandom);
      end
      m_if.awready = ($urandom_range(0, 3) != 0);
      m_if.wready  = ($urandom_range(0, 3) != 0);
      m_if.arready = ($urandom_range(0, 2) != 0);
      s_if.bready  = ($urandom_range(0, 3) != 0);
      s_if.rready  = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic drain();
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1; s_if.bready = 1; s_if.rready = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (s_if.awvalid && s_if.awready) s_if.awvalid = 0;
      if (s_if.wvalid && s_if.wready)   s_if.wvalid = 0;
      if (s_if.arvalid && s_if.arready) s_if.arvalid = 0;
      if (m_if.bvalid && m_if.bready)   m_if.bvalid = 0;
      if (m_if.rvalid && m_if.rready)   m_if.rvalid = 0;
      @(posedge clk); #1;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic prev;
    int nhs;
`ifdef MY_AXIL_SLICE_STATS_EN
    logic [31:0] wr_ref;
`endif
    s_if.awvalid = 1; s_if.awaddr = 32'h100; s_if.awprot = 3'd0;
    s_if.wvalid = 0; s_if.wdata = '0; s_if.wstrb = '0;
    s_if.arvalid = 0; s_if.araddr = '0; s_if.arprot = '0;
    s_if.bready = 1; s_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    m_if.bvalid = 0; m_if.bresp = '0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0;
    sb_if.awvalid = 0; sb_if.awaddr = '0; sb_if.awprot = '0; sb_if.wvalid = 0; sb_if.wdata = '0;
    sb_if.wstrb = '0; sb_if.arvalid = 0; sb_if.araddr = '0; sb_if.arprot = '0;
    sb_if.bready = 0; sb_if.rready = 0;
    mb_if.awready = 0; mb_if.wready = 0; mb_if.arready = 0; mb_if.bvalid = 0; mb_if.bresp = '0;
    mb_if.rvalid = 0; mb_if.rdata = '0; mb_if.rresp = '0;

    // Reset behaviour
    repeat (5) begin
      @(negedge clk);
      chk("rst_m_awvalid", m_if.awvalid, 0);
      chk("rst_s_awready", s_if.awready, 0);
      chk("rst_s_bvalid", s_if.bvalid, 0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("awready_before_first_edge", s_if.awready, 0);
    @(negedge clk);
    chk("awready_after_release", s_if.awready, 1);
    @(posedge clk); #1;
    s_if.awvalid = 0;
    repeat (2) @(posedge clk);
    #1;

`ifdef MY_AXIL_SLICE_STATS_EN
    send_b(3);
    send_r(5);
    repeat (4) @(negedge clk);
    chk("stats_wr_cnt", wr_cnt, 32'd3);
    chk("stats_rd_cnt", rd_cnt, 32'd5);
    @(posedge clk); #1;
    force dut.wr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt;
    wr_ref = exp_wr;
    @(posedge clk); #1;
    send_b(1);
    repeat (4) @(negedge clk);
    chk("stats_wr_wrap", wr_cnt, 32'd0);
    @(posedge clk); #1;
`endif

    // Back-to-back writes
    aw_out_log.delete(); aw_lat_log.delete();
    for (int i = 0; i < 8; i++) send_aw_w(32'(i * 4));
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_aw_count", aw_out_log.size(), 8);
    for (int i = 0; i < aw_lat_log.size(); i++) chk("b2b_latency", aw_lat_log[i], 1);
    for (int i = 1; i < aw_out_log.size(); i++) chk("b2b_no_bubble", aw_out_log[i] - aw_out_log[i-1], 1);

    // AR backpressure into the skid register
    m_if.arready = 0;
    ar_out_log.delete();
    send_ar(32'h40);
    send_ar(32'h44);
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_arready_low", s_if.arready, 0);
      chk("bp_m_arvalid", m_if.arvalid, 1);
      chk("bp_m_araddr", m_if.araddr, 32'h40);
    end
    @(posedge clk); #1;
    m_if.arready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ar_count", ar_out_log.size(), 2);
    if (ar_out_log.size() == 2) chk("bp_ar_consecutive", ar_out_log[1] - ar_out_log[0], 1);

    // SIMPLE B: one beat per two cycles
    s_if.bready = 1;
    m_if.bvalid = 1; m_if.bresp = RESP_SLVERR;
    @(negedge clk);
    prev = s_if.bvalid;
    nhs = 0;
    repeat (8) begin
      @(negedge clk);
      chk("b_toggle", s_if.bvalid, !prev);
      if (s_if.bvalid) chk("b_slverr", s_if.bresp, RESP_SLVERR);
      if (s_if.bvalid && s_if.bready) nhs++;
      prev = s_if.bvalid;
    end
    chk("b_rate", nhs, 4);
    if (!m_if.bready) @(negedge clk);
    @(posedge clk); #1;
    m_if.bvalid = 0;
    repeat (3) @(posedge clk);
    #1;

    // BYPASS R on the second instance
    sb_if.rready = 0;
    mb_if.rvalid = 1; mb_if.rdata = 32'hDEAD_BEEF; mb_if.rresp = RESP_OKAY;
    #1;
    chk("byp_rdata_same_cycle", sb_if.rdata, 32'hDEAD_BEEF);
    chk("byp_rvalid_same_cycle", sb_if.rvalid, 1);
    chk("byp_rready_low", mb_if.rready, 0);
    sb_if.rready = 1;
    #1;
    chk("byp_rready_high", mb_if.rready, 1);
    @(posedge clk); #1;
    mb_if.rdata = 32'h1234_5678; mb_if.rresp = RESP_SLVERR;
    #1;
    chk("byp_rdata_follow", sb_if.rdata, 32'h1234_5678);
    chk("byp_rresp_follow", sb_if.rresp, RESP_SLVERR);
    @(posedge clk); #1;
    mb_if.rvalid = 0;
    sb_if.rready = 0;

    // Randomized traffic on every channel
    random_phase(400);
    drain();

    chk("final_q_aw_empty", q_aw.size(), 0);
    chk("final_q_w_empty", q_w.size(), 0);
    chk("final_q_ar_empty", q_ar.size(), 0);
    chk("final_q_b_empty", q_b.size(), 0);
    chk("final_q_r_empty", q_r.size(), 0);
    chk("final_q_rb_empty", q_rb.size(), 0);
`ifdef MY_AXIL_SLICE_STATS_EN
    chk("final_wr_cnt", wr_cnt, 32'hFFFF_FFFF + (exp_wr - wr_ref));
    chk("final_rd_cnt", rd_cnt, exp_rd);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/my_axil_reg_slice.md
Name: my_axil_reg_slice

Overview:
- Parametrised AXI4-Lite register slice, inserted between a `my_axil_if` master and slave to break timing paths on all five channels.
- Each channel (AW, W, B, AR, R) is independently configurable as bypass, simple one-entry register, or full-throughput two-entry skid buffer.
- Used at crossbar boundaries and in front of the AES/UART register blocks.
- Adds no protocol conversion: the payload is forwarded bit-exact.

Parameters:
- ADDR_W, 32, address width of both interfaces.
- DATA_W, 32, data width; must be 32 or 64. wstrb width is DATA_W/8.
- AW_MODE, SLICE_SKID, mode of the write address channel (SLICE_BYPASS / SLICE_SIMPLE / SLICE_SKID).
- W_MODE, SLICE_SKID, mode of the write data channel.
- B_MODE, SLICE_SIMPLE, mode of the write response channel.
- AR_MODE, SLICE_SKID, mode of the read address channel.
- R_MODE, SLICE_SKID, mode of the read data channel.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axil  `my_axil_if.slave`  ADDR_W/DATA_W  upstream side; connects to the master.
- m_axil  `my_axil_if.master`  ADDR_W/DATA_W  downstream side; connects to the slave.
- wr_cnt  out  32  completed B handshakes on s_axil (only with MY_AXIL_SLICE_STATS_EN).
- rd_cnt  out  32  completed R handshakes on s_axil (only with MY_AXIL_SLICE_STATS_EN).

Behaviour:
- Channel direction:
  - AW, W, AR: forward from s_axil to m_axil.
  - B, R: forward from m_axil to s_axil.
- Payload per channel:
  - AW: awaddr, awprot.
  - W: wdata, wstrb.
  - B: bresp.
  - AR: araddr, arprot.
  - R: rdata, rresp.
- Reset (asynchronous assert, synchronous release):
  - All output valids = 0, all output readies = 0, payload registers = 0.
  - Readies rise on the first clk edge after rst_n deasserts.
- SLICE_BYPASS:
  - Pure wires, zero latency, no state.
  - Output readies follow the downstream readies combinationally.
- SLICE_SIMPLE:
  - One register, latency 1.
  - in_ready = ~full, registered; there is no combinational path in either direction.
  - Fill on in handshake; drain on out handshake.
  - Max throughput 1 beat per 2 cycles.
- SLICE_SKID:
  - Main register plus skid register; latency 1; full throughput; no combinational path in either direction.
  - States:
    - EMPTY -> ONE on input handshake.
    - ONE -> EMPTY on output handshake with no input.
    - ONE stays ONE on simultaneous input and output handshake; main register reloads in the same cycle.
    - ONE -> TWO on input handshake while output is stalled; the beat goes to the skid register.
    - TWO -> ONE on output handshake; skid moves into main.
  - in_ready = (state != TWO), registered; it drops the cycle after the skid register fills.
- Every channel obeys AXI rules:
  - Output payload is stable while valid=1 and ready=0.
  - valid never deasserts without a handshake.
  - Beat order is preserved per channel.
- No ordering is enforced between AW and W; the downstream slave handles skew.
- rst_n assertion mid-transaction discards held beats immediately. The environment must reset both sides together.

Optional Feature:
- MY_AXIL_SLICE_STATS_EN defined:
  - wr_cnt and rd_cnt exist, reset to 0, increment by 1 on each s_axil B and R handshake respectively.
  - Both wrap from 0xFFFFFFFF to 0.
  - Handshakes on B and R in the same cycle increment both counters.
- Undefined: the ports and counters are absent.

Decomposition:
- `my_axil_pkg`:
  - typedef enum logic [1:0] slice_mode_e {SLICE_BYPASS=0, SLICE_SIMPLE=1, SLICE_SKID=2}.
  - localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Function `axil_strb_w(DATA_W)`.
- Sub-module `my_axil_skid_buf`:
  - Parameters WIDTH and MODE; generic valid/ready/payload.
  - Instantiated five times with packed payload widths:
    - AW and AR: ADDR_W+3.
    - W: DATA_W+DATA_W/8.
    - B: 2.
    - R: DATA_W+2.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with s.awvalid=1 -> m.awvalid=0 and s.awready=0 during reset; s.awready=1 one cycle after release.
- Back-to-back writes, all SKID: 8 AW/W beats with awaddr 0x00..0x1C, m.ready=1 -> 8 m-side beats, latency 1, zero bubbles, addresses in order.
- Backpressure: m.arready=0 for 3 cycles while s.arvalid=1 with araddr 0x40, 0x44:
  - both beats held, s.arready drops after the second beat;
  - on release, 0x40 then 0x44 emerge in consecutive cycles;
  - araddr is stable throughout the stall.
- SIMPLE B channel: m.bvalid held at 1 with bresp=SLVERR, s.bready=1 -> s.bvalid toggles one beat per 2 cycles, bresp=2'b10 preserved.
- BYPASS R: R_MODE=SLICE_BYPASS, m.rdata=0xDEADBEEF -> s.rdata equals it in the same cycle, and s.rready passes through combinationally.
- Stats, with MY_AXIL_SLICE_STATS_EN: 3 writes and 5 reads -> wr_cnt=3, rd_cnt=5. Preload the counter to 0xFFFFFFFF by force, then one write -> wr_cnt=0.
